// File: rtl/exam_pkg.sv
// Shared definitions for the result-stream consumers: default sample width,
// window-statistics FSM encoding and the signed saturation limits.
package exam_pkg;

    localparam int EXAM_DW = 20;

    typedef enum logic [0:0] {
        ST_ACC    = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    // Largest and smallest representable samples at the default width.
    localparam logic signed [EXAM_DW-1:0] SMAX = {1'b0, {(EXAM_DW-1){1'b1}}};
    localparam logic signed [EXAM_DW-1:0] SMIN = {1'b1, {(EXAM_DW-1){1'b0}}};

endpackage

// File: rtl/result_window_stats_if.sv
// Sample input handshake plus the per-window statistics outputs.
interface result_window_stats_if
    import exam_pkg::*;
#(
    parameter int DW       = EXAM_DW,
    parameter int WIN_LOG2 = 3
);
    logic                         in_valid;
    logic signed [DW-1:0]         in_data;
    logic                         in_ready;
    logic                         flush;
    logic                         stat_valid;
    logic signed [DW-1:0]         stat_min;
    logic signed [DW-1:0]         stat_max;
    logic signed [DW+WIN_LOG2-1:0] stat_sum;
    logic signed [DW-1:0]         stat_avg;
    logic [WIN_LOG2-1:0]          count;

    // Producer / monitor side.
    modport master (
        output in_valid, in_data, flush,
        input  in_ready, stat_valid, stat_min, stat_max, stat_sum, stat_avg, count
    );

    // Statistics block side.
    modport slave (
        input  in_valid, in_data, flush,
        output in_ready, stat_valid, stat_min, stat_max, stat_sum, stat_avg, count
    );
endinterface

// File: rtl/signed_minmax.sv
// Combinational update of a running signed minimum and maximum.
module signed_minmax #(
    parameter int DW = 20
) (
    input  logic signed [DW-1:0] cur_min,
    input  logic signed [DW-1:0] cur_max,
    input  logic signed [DW-1:0] sample,
    output logic signed [DW-1:0] new_min,
    output logic signed [DW-1:0] new_max
);

    // All operands are signed, so these are two's-complement compares.
    always_comb begin
        new_min = (sample < cur_min) ? sample : cur_min;
        new_max = (sample > cur_max) ? sample : cur_max;
    end

endmodule

// File: rtl/result_window_stats.sv
// Windowed statistics over a signed sample stream: groups 2^WIN_LOG2 accepted
// samples and reports min, max, exact sum and floor average with a one-cycle
// strobe. A one-cycle REPORT state backpressures the producer after each window.
module result_window_stats
    import exam_pkg::*;
#(
    parameter int DW       = EXAM_DW,
    parameter int WIN_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,    // asynchronous, active low
    result_window_stats_if.slave  bus
);

    localparam int SW = DW + WIN_LOG2;

    // Accumulator start values: min starts at the largest value, max at the smallest.
    localparam logic signed [DW-1:0] SAT_MAX =
        (DW == EXAM_DW) ? DW'(SMAX) : {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN =
        (DW == EXAM_DW) ? DW'(SMIN) : {1'b1, {(DW-1){1'b0}}};

    localparam logic [WIN_LOG2-1:0] CNT_LAST = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);

    state_t                state_q, state_d;
    logic [WIN_LOG2-1:0]   count_q, count_d;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic signed [DW-1:0]  min_q, min_d;
    logic signed [DW-1:0]  max_q, max_d;

    logic                  stat_valid_q, stat_valid_d;
    logic signed [DW-1:0]  stat_min_q, stat_min_d;
    logic signed [DW-1:0]  stat_max_q, stat_max_d;
    logic signed [SW-1:0]  stat_sum_q, stat_sum_d;
    logic signed [DW-1:0]  stat_avg_q, stat_avg_d;

    logic signed [SW-1:0]  sample_ext;
    logic signed [SW-1:0]  sum_acc;
    logic signed [DW-1:0]  mm_min;
    logic signed [DW-1:0]  mm_max;

    // Sign-extend each sample to the accumulator width so the sum cannot wrap.
    assign sample_ext = {{WIN_LOG2{bus.in_data[DW-1]}}, bus.in_data};
    assign sum_acc    = sum_q + sample_ext;

    signed_minmax #(.DW(DW)) u_minmax (
        .cur_min (min_q),
        .cur_max (max_q),
        .sample  (bus.in_data),
        .new_min (mm_min),
        .new_max (mm_max)
    );

    // Next-state logic for the window FSM, accumulators and reported statistics.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sum_d        = sum_q;
        min_d        = min_q;
        max_d        = max_q;
        stat_valid_d = 1'b0;
        stat_min_d   = stat_min_q;
        stat_max_d   = stat_max_q;
        stat_sum_d   = stat_sum_q;
        stat_avg_d   = stat_avg_q;

        case (state_q)
            ST_ACC: begin
                if (bus.flush) begin
                    // Flush beats a concurrent sample; the partial window is dropped.
                    count_d = '0;
                    sum_d   = '0;
                    min_d   = SAT_MAX;
                    max_d   = SAT_MIN;
                end else if (bus.in_valid) begin
                    if (count_q == CNT_LAST) begin
                        // Final sample of the window: publish results including it.
                        stat_min_d   = mm_min;
                        stat_max_d   = mm_max;
                        stat_sum_d   = sum_acc;
                        // Dropping the low WIN_LOG2 bits of the signed sum is an
                        // arithmetic shift, i.e. floor division by the window length.
                        stat_avg_d   = sum_acc[SW-1:WIN_LOG2];
                        stat_valid_d = 1'b1;
                        count_d      = '0;
                        sum_d        = '0;
                        min_d        = SAT_MAX;
                        max_d        = SAT_MIN;
                        state_d      = ST_REPORT;
                    end else begin
                        sum_d   = sum_acc;
                        min_d   = mm_min;
                        max_d   = mm_max;
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            ST_REPORT: begin
                // Single strobe cycle; input is stalled and flush has no effect.
                state_d = ST_ACC;
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_ACC;
            count_q      <= '0;
            sum_q        <= '0;
            min_q        <= SAT_MAX;
            max_q        <= SAT_MIN;
            stat_valid_q <= 1'b0;
            stat_min_q   <= '0;
            stat_max_q   <= '0;
            stat_sum_q   <= '0;
            stat_avg_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            min_q        <= min_d;
            max_q        <= max_d;
            stat_valid_q <= stat_valid_d;
            stat_min_q   <= stat_min_d;
            stat_max_q   <= stat_max_d;
            stat_sum_q   <= stat_sum_d;
            stat_avg_q   <= stat_avg_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_ACC);
    assign bus.stat_valid = stat_valid_q;
    assign bus.stat_min   = stat_min_q;
    assign bus.stat_max   = stat_max_q;
    assign bus.stat_sum   = stat_sum_q;
    assign bus.stat_avg   = stat_avg_q;
    assign bus.count      = count_q;

endmodule

// File: doc/result_window_stats.md
Name: result_window_stats

Overview:
Consumer for the signed 20-bit `result` stream produced by the exam1-style generators. Accepts samples over a valid/ready handshake and groups them into fixed windows of 2^WIN_LOG2 samples. For each window it reports min, max, sum and floor-average, with a one-cycle strobe. Sits downstream of a result generator as a monitor and statistics block.

Parameters:
- DW, 20, sample width in bits; samples are two's-complement signed.
- WIN_LOG2, 3, log2 of the window length; N = 2^WIN_LOG2; legal range 1..8.

Ports:
- clk, input, 1, sole clock; all state changes on the rising edge.
- rst, input, 1, asynchronous, active-low reset (rst==0 resets).
- in_valid, input, 1, in_data holds a sample.
- in_data, input, DW, signed sample.
- in_ready, output, 1, block can accept a sample this cycle.
- flush, input, 1, discard the partial window.
- stat_valid, output, 1, one-cycle strobe: window statistics are valid.
- stat_min, output, DW, signed minimum of the window.
- stat_max, output, DW, signed maximum of the window.
- stat_sum, output, DW+WIN_LOG2, signed exact sum of the window.
- stat_avg, output, DW, signed value equal to stat_sum >>> WIN_LOG2 (floor).
- count, output, WIN_LOG2, samples accepted in the current window.

Behaviour:
- Reset (async assert, sync-to-clk deassert not required):
  - FSM goes to ACC.
  - All stat_*, count and stat_valid go to 0.
  - Accumulators clear: sum=0, min=+max (2^(DW-1)-1), max=-max (-2^(DW-1)).
- A sample is accepted at a rising edge where in_valid && in_ready && !flush.
- FSM states:
  - ACC: in_ready=1. Each accepted sample does sum+=sample, min=min(min,sample), max=max(max,sample) (signed compares), count+=1.
    - If the accepted sample is the Nth (count==N-1), then on that same edge:
      - stat_min, stat_max, stat_sum and stat_avg load the final values, including that sample.
      - Accumulators and count clear.
      - FSM goes to REPORT.
  - REPORT: lasts exactly one cycle. stat_valid=1, in_ready=0, and no sample is accepted. The next edge returns to ACC.
- Latency: stat_valid is high in the cycle immediately after the edge that accepts the Nth sample.
- Throughput: at most N samples per N+1 cycles.
- stat_* hold their values until the next window completes; they are not cleared by a REPORT exit or by flush.
- Widths and arithmetic:
  - The sum accumulator is DW+WIN_LOG2 bits, sign-extended per sample, so it never overflows.
  - The average is an arithmetic right shift, so it rounds toward -infinity.
  - The average always fits in DW bits.
- flush in ACC: clears accumulators and count at the edge. A concurrent in_valid sample is dropped (flush wins). No stat_valid is produced.
- flush in REPORT: ignored. The report completes normally.
- in_valid held high while in REPORT: the sample is not consumed. The producer must hold it; it is accepted on the first ACC cycle.
- count wraps N-1 → 0 only via window completion.
- Reset mid-window: the partial window is lost. If reset is asserted during REPORT, stat_valid drops immediately (asynchronously).
- in_data is ignored whenever in_valid==0.

Decomposition:
- Shared package `exam_pkg` holds:
  - DW default (20).
  - State encoding ST_ACC / ST_REPORT.
  - Constants SMAX = 2^(DW-1)-1 and SMIN = -2^(DW-1).
- One natural sub-module, `signed_minmax`: combinational signed min/max of the running value and the new sample, parameterised by DW.
- Everything else stays in the top module.

Test Plan:
All scenarios use WIN_LOG2=3 (N=8).
1. Reset, then in_valid held with samples 1..8 → one cycle after the 8th, stat_valid=1 with min=1, max=8, sum=36, avg=4. in_ready=0 in that cycle.
2. Samples -1..-8 → min=-8, max=-1, sum=-36, avg=-5 (floor, not -4).
3. Eight samples of -524288, then eight of 524287 → first report sum=-4194304, avg=-524288. Second report sum=4194296, avg=524287. No wrap in either.
4. Continuous in_valid for 16 samples → sample 9 is held during REPORT and accepted the next cycle. Two strobes appear 9 cycles apart, and no sample is lost or duplicated (check with an incrementing pattern).
5. Accept 5 samples, assert flush with in_valid=1, then feed 8 samples 10..17 → no strobe after the first 5. The report shows min=10, max=17, sum=108, avg=13.
6. Assert rst low asynchronously mid-window and during REPORT → outputs zero immediately with no clk edge. After release, a full window reports correctly.
